// File: rtl/alu_rs_scheduler.sv
// Reservation station and issue scheduler for the shared combinational ALU.
// Buffers decoded ALU ops, snoops the CDB for missing operands, and each cycle
// sends the lowest-index ready entry to the ALU. The ALU result is held in an
// output register until the CDB arbiter acknowledges it.
//
// Ports:
//   clk, rst (sync, active-high), rdy (low = freeze), flush (drop everything)
//   in_*      : insert request (op, dest tag, operand values/producer tags/valid bits)
//   full      : no free entry
//   cdb_*     : CDB broadcast used for operand wakeup
//   alu_*     : combinational ALU request/operands, result and accept back
//   out_*     : held result (valid, tag, data) and arbiter acknowledge
module alu_rs_scheduler #(
  parameter int unsigned ENTRIES = 8,
  parameter int unsigned TAG_W   = 4,
  parameter int unsigned OP_W    = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rdy,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [OP_W-1:0]  in_op,
  input  logic [TAG_W-1:0] in_tag,
  input  logic [31:0]      in_lv,
  input  logic [31:0]      in_rv,
  input  logic [TAG_W-1:0] in_lq,
  input  logic [TAG_W-1:0] in_rq,
  input  logic             in_lrdy,
  input  logic             in_rrdy,
  output logic             full,
  input  logic             cdb_valid,
  input  logic [TAG_W-1:0] cdb_tag,
  input  logic [31:0]      cdb_data,
  output logic             alu_ready,
  output logic [OP_W-1:0]  alu_op,
  output logic [31:0]      alu_lv,
  output logic [31:0]      alu_rv,
  input  logic [31:0]      alu_result,
  input  logic             alu_success,
  output logic             out_valid,
  output logic [TAG_W-1:0] out_tag,
  output logic [31:0]      out_data,
  input  logic             out_ack
);
  localparam int unsigned IdxW = $clog2(ENTRIES);

  logic [ENTRIES-1:0] busy_q, busy_d, lrdy_q, lrdy_d, rrdy_q, rrdy_d;
  logic [OP_W-1:0]    op_q  [ENTRIES];
  logic [OP_W-1:0]    op_d  [ENTRIES];
  logic [TAG_W-1:0]   tag_q [ENTRIES];
  logic [TAG_W-1:0]   tag_d [ENTRIES];
  logic [TAG_W-1:0]   lq_q  [ENTRIES];
  logic [TAG_W-1:0]   lq_d  [ENTRIES];
  logic [TAG_W-1:0]   rq_q  [ENTRIES];
  logic [TAG_W-1:0]   rq_d  [ENTRIES];
  logic [31:0]        lv_q  [ENTRIES];
  logic [31:0]        lv_d  [ENTRIES];
  logic [31:0]        rv_q  [ENTRIES];
  logic [31:0]        rv_d  [ENTRIES];

  logic             out_valid_q, out_valid_d;
  logic [TAG_W-1:0] out_tag_q, out_tag_d;
  logic [31:0]      out_data_q, out_data_d;

  logic [ENTRIES-1:0] entry_ready;
  logic [IdxW-1:0]    free_idx, sel_idx;
  logic               sel_found, dispatch, insert, lhit, rhit;

  // The ALU accept is tied to our own request by protocol; nothing to recover from.
  logic unused_alu_success;
  assign unused_alu_success = alu_success;

  // Only registered state decides eligibility: no same-cycle bypass to the ALU.
  assign entry_ready = busy_q & lrdy_q & rrdy_q;
  assign full        = &busy_q;

  // Descending scan so the last hit is the lowest index.
  always_comb begin
    free_idx  = '0;
    sel_idx   = '0;
    sel_found = 1'b0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (!busy_q[i]) free_idx = IdxW'(i);
      if (entry_ready[i]) begin
        sel_idx   = IdxW'(i);
        sel_found = 1'b1;
      end
    end
  end

  assign dispatch  = rdy & ~rst & ~flush & sel_found & (~out_valid_q | out_ack);
  assign insert    = rdy & ~flush & in_valid & ~full;
  assign lhit      = ~in_lrdy & cdb_valid & (cdb_tag == in_lq);
  assign rhit      = ~in_rrdy & cdb_valid & (cdb_tag == in_rq);

  assign alu_ready = dispatch;
  assign alu_op    = dispatch ? op_q[sel_idx] : '0;
  assign alu_lv    = dispatch ? lv_q[sel_idx] : '0;
  assign alu_rv    = dispatch ? rv_q[sel_idx] : '0;

  assign out_valid = out_valid_q;
  assign out_tag   = out_tag_q;
  assign out_data  = out_data_q;

  // Entry next state. Wakeup only touches busy entries and insert only a free
  // one, so the two never collide; a dispatched entry has no waiting operand.
  always_comb begin
    busy_d = busy_q;
    lrdy_d = lrdy_q;
    rrdy_d = rrdy_q;
    op_d   = op_q;
    tag_d  = tag_q;
    lq_d   = lq_q;
    rq_d   = rq_q;
    lv_d   = lv_q;
    rv_d   = rv_q;
    if (rdy) begin
      if (flush) begin
        busy_d = '0;
      end else begin
        for (int i = 0; i < ENTRIES; i++) begin
          if (busy_q[i] && cdb_valid) begin
            if (!lrdy_q[i] && lq_q[i] == cdb_tag) begin
              lrdy_d[i] = 1'b1;
              lv_d[i]   = cdb_data;
            end
            if (!rrdy_q[i] && rq_q[i] == cdb_tag) begin
              rrdy_d[i] = 1'b1;
              rv_d[i]   = cdb_data;
            end
          end
        end
        if (dispatch) busy_d[sel_idx] = 1'b0;
        if (insert) begin
          busy_d[free_idx] = 1'b1;
          op_d[free_idx]   = in_op;
          tag_d[free_idx]  = in_tag;
          lq_d[free_idx]   = in_lq;
          rq_d[free_idx]   = in_rq;
          lrdy_d[free_idx] = in_lrdy | lhit;
          rrdy_d[free_idx] = in_rrdy | rhit;
          lv_d[free_idx]   = lhit ? cdb_data : in_lv;
          rv_d[free_idx]   = rhit ? cdb_data : in_rv;
        end
      end
    end
  end

  // Output register: a new result replaces an acked one in the same cycle.
  always_comb begin
    out_valid_d = out_valid_q;
    out_tag_d   = out_tag_q;
    out_data_d  = out_data_q;
    if (rdy) begin
      if (flush) begin
        out_valid_d = 1'b0;
      end else if (dispatch) begin
        out_valid_d = 1'b1;
        out_tag_d   = tag_q[sel_idx];
        out_data_d  = alu_result;
      end else if (out_ack) begin
        out_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q      <= '0;
      lrdy_q      <= '0;
      rrdy_q      <= '0;
      out_valid_q <= 1'b0;
      out_tag_q   <= '0;
      out_data_q  <= '0;
    end else begin
      busy_q      <= busy_d;
      lrdy_q      <= lrdy_d;
      rrdy_q      <= rrdy_d;
      out_valid_q <= out_valid_d;
      out_tag_q   <= out_tag_d;
      out_data_q  <= out_data_d;
    end
  end

  // Payload is qualified by busy/ready bits, so it needs no reset.
  always_ff @(posedge clk) begin
    op_q  <= op_d;
    tag_q <= tag_d;
    lq_q  <= lq_d;
    rq_q  <= rq_d;
    lv_q  <= lv_d;
    rv_q  <= rv_d;
  end

endmodule
